imem_access_ctrl: RTL

- Sequencer and arbiter for the byte-wide, single-port instruction memory.
- Shares the port between two requesters:
  - the CPU fetch stage, which reads 32-bit instructions;
  - the program loader, which writes 32-bit words.
- Each 32-bit transfer is serialised into 4 big-endian byte beats: byte at addr holds bits [31:24], byte at addr+3 holds bits [7:0].
- Sits between the PC/fetch logic and the instruction memory array.

---
 rtl/imem_pkg.sv | 28 ++
 rtl/imem_word_packer.sv | 38 +++
 rtl/imem_access_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-memory access controller.
// The optional address check is enabled by defining IMEM_ADDR_CHECK_EN.
package imem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_LAST,
        RSP,
        WR
    } state_e;

    localparam int BYTES_PER_WORD    = 4;
    localparam int MEM_BYTES_DEFAULT = 1024;

    // Big-endian lane: beat 0 carries bits [31:24], beat 3 carries bits [7:0].
    function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] beat);
        logic [7:0] lane;
        case (beat)
            2'd0:    lane = word[31:24];
            2'd1:    lane = word[23:16];
            2'd2:    lane = word[15:8];
            default: lane = word[7:0];
        endcase
        return lane;
    endfunction

endpackage

// File: rtl/imem_word_packer.sv
// 32-bit assembly register for read data; bytes enter at the low end so the
// first byte read ends up in bits [31:24] after four shifts.
module imem_word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_i,
    input  logic        load_i,
    input  logic [31:0] load_word_i,
    input  logic        shift_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o
);

    logic [31:0] word_q;
    logic [31:0] word_d;

    always_comb begin
        word_d = word_q;
        if (clr_i) begin
            word_d = '0;
        end else if (load_i) begin
            word_d = load_word_i;
        end else if (shift_i) begin
            word_d = {word_q[23:0], byte_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign word_o = word_q;

endmodule

// File: rtl/imem_access_ctrl.sv
// Arbiter/sequencer sharing the byte-wide instruction memory between CPU fetch
// (reads) and the program loader (writes). Address checking: IMEM_ADDR_CHECK_EN.
//
// state   | meaning
// IDLE    | port free; loader has priority over fetch
// RD      | issuing read beats 0..3
// RD_LAST | capturing the final read byte
// RSP     | holding the fetch response until f_rsp_ready
// WR      | issuing write beats 0..3 (not abortable)
module imem_access_ctrl
    import imem_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEFAULT,
    parameter int AW        = 32,
    parameter int MAW       = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           f_req_valid,
    output logic           f_req_ready,
    input  logic [AW-1:0]  f_req_addr,
    input  logic           f_flush,
    output logic           f_rsp_valid,
    input  logic           f_rsp_ready,
    output logic [31:0]    f_rsp_inst,
    output logic           f_rsp_err,
    input  logic           ld_valid,
    output logic           ld_ready,
    input  logic [AW-1:0]  ld_addr,
    input  logic [31:0]    ld_data,
    output logic           ld_err,
    output logic [MAW-1:0] mem_addr,
    output logic           mem_rd_en,
    input  logic [7:0]     mem_rdata,
    output logic           mem_wr_en,
    output logic [7:0]     mem_wdata,
    output logic           busy
);

    state_e         state_q, state_d;
    logic [1:0]     beat_q, beat_d;
    logic [MAW-1:0] base_q, base_d;
    logic [31:0]    wdata_q, wdata_d;
    logic           err_q, err_d;
    logic           ld_err_q, ld_err_d;
    logic           rd_pend_q;

    logic           pk_clr;
    logic           pk_shift;
    logic [31:0]    pk_word;
    logic           f_addr_err;
    logic           ld_addr_err;

`ifdef IMEM_ADDR_CHECK_EN
    localparam logic [AW-1:0] LAST_WORD_ADDR = AW'(MEM_BYTES - BYTES_PER_WORD);

    assign f_addr_err  = (f_req_addr[1:0] != 2'b00) || (f_req_addr > LAST_WORD_ADDR);
    assign ld_addr_err = (ld_addr[1:0] != 2'b00) || (ld_addr > LAST_WORD_ADDR);
`else
    // Without checking, only the low MAW bits matter; accesses wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{f_req_addr[AW-1:MAW], ld_addr[AW-1:MAW]};
    assign f_addr_err  = 1'b0;
    assign ld_addr_err = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        ld_err_d    = 1'b0;
        pk_clr      = 1'b0;
        // A read byte arrives one cycle after its strobe; ignore stragglers after a flush.
        pk_shift    = rd_pend_q && ((state_q == RD) || (state_q == RD_LAST));
        f_req_ready = 1'b0;
        ld_ready    = 1'b0;
        f_rsp_valid = 1'b0;
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;

        unique case (state_q)
            IDLE: begin
                // Gated by rst_n so every output reads 0 while reset is held.
                ld_ready    = rst_n;
                f_req_ready = rst_n && !ld_valid;
                if (ld_valid) begin
                    if (ld_addr_err) begin
                        ld_err_d = 1'b1;
                    end else begin
                        base_d  = ld_addr[MAW-1:0];
                        wdata_d = ld_data;
                        beat_d  = 2'd0;
                        state_d = WR;
                    end
                end else if (f_req_valid) begin
                    base_d  = f_req_addr[MAW-1:0];
                    beat_d  = 2'd0;
                    pk_clr  = 1'b1;
                    err_d   = f_addr_err;
                    state_d = f_addr_err ? RSP : RD;
                end
            end
            WR: begin
                mem_wr_en = 1'b1;
                mem_addr  = base_q + MAW'(beat_q);
                mem_wdata = byte_lane(wdata_q, beat_q);
                beat_d    = beat_q + 2'd1;
                if (beat_q == 2'd3) begin
                    state_d = IDLE;
                end
            end
            RD: begin
                mem_rd_en = 1'b1;
                mem_addr  = base_q + MAW'(beat_q);
                beat_d    = beat_q + 2'd1;
                if (f_flush) begin
                    state_d = IDLE;
                end else if (beat_q == 2'd3) begin
                    state_d = RD_LAST;
                end
            end
            RD_LAST: begin
                state_d = f_flush ? IDLE : RSP;
            end
            RSP: begin
                f_rsp_valid = 1'b1;
                if (f_flush || f_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            base_q    <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            ld_err_q  <= 1'b0;
            rd_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            base_q    <= base_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            ld_err_q  <= ld_err_d;
            rd_pend_q <= mem_rd_en;
        end
    end

    imem_word_packer u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (pk_clr),
        .load_i      (1'b0),
        .load_word_i (32'h0),
        .shift_i     (pk_shift),
        .byte_i      (mem_rdata),
        .word_o      (pk_word)
    );

    assign f_rsp_inst = pk_word;
    assign f_rsp_err  = (state_q == RSP) && err_q;
    assign ld_err     = ld_err_q;
    assign busy       = (state_q != IDLE);

endmodule
